pipeline_to_buffer: RTL and testbench

//  Sink at the output end of the disparity pipeline: takes one depth pixel per valid

---
 rtl/pipeline_to_buffer_if.sv | 31 +++
 rtl/pipeline_to_buffer.sv | 131 +++++++++++++
 tb/tb_pipeline_to_buffer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_to_buffer_if.sv
// Bundle between the disparity pipeline / line reader and the ping-pong line buffer.
// Handshake: pixel_valid qualifies pixel_in for one cycle with no ready, so the sink never
// stalls the pipeline. read_enable qualifies read_address, and data_out is valid one clock
// later. line_ready is a single-cycle strobe.
interface pipeline_to_buffer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  logic                  line_start;
  logic                  pixel_valid;
  logic [DATA_WIDTH-1:0] pixel_in;
  logic                  read_enable;
  logic [ADDR_WIDTH-1:0] read_address;
  logic                  error_clear;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  line_ready;
  logic                  line_valid;
  logic [ADDR_WIDTH-1:0] line_count;
  logic                  drop_error;
  logic                  short_error;

  modport master (
    output line_start, pixel_valid, pixel_in, read_enable, read_address, error_clear,
    input  data_out, line_ready, line_valid, line_count, drop_error, short_error
  );

  modport slave (
    input  line_start, pixel_valid, pixel_in, read_enable, read_address, error_clear,
    output data_out, line_ready, line_valid, line_count, drop_error, short_error
  );
endinterface

// File: rtl/pipeline_to_buffer.sv
// Ping-pong line buffer at the end of the disparity pipeline: one bank fills from the
// pipeline while the reader fetches the last completed line from the other bank.
module pipeline_to_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int LINE_WIDTH = 640,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                clock,
  input  logic                reset_n,
  pipeline_to_buffer_if.slave bus,
  output logic [0:0]          state_debug
);

  localparam int RAM_DEPTH = 2 * LINE_WIDTH;
  localparam int RAM_AW    = $clog2(RAM_DEPTH);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LINE_WIDTH - 1);
  localparam logic [RAM_AW-1:0]     BANK_OFS  = RAM_AW'(LINE_WIDTH);

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] write_address_q, write_address_d;
  logic [ADDR_WIDTH-1:0] wr_addr_eff;
  logic                  wr_bank_q, rd_bank_q;
  logic                  line_ready_q, line_valid_q;
  logic [ADDR_WIDTH-1:0] line_count_q;
  logic                  drop_error_q, short_error_q;
  logic [DATA_WIDTH-1:0] data_out_q;

  logic                  ram_we;
  logic                  line_done;
  logic                  drop_evt, short_evt;
  logic [RAM_AW-1:0]     wr_idx, rd_idx;
  logic                  rd_in_range;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  // A line_start always wins over the current line and restarts at address 0 in the
  // same bank; a pixel on the same cycle becomes pixel 0.
  always_comb begin
    state_d         = state_q;
    write_address_d = write_address_q;
    wr_addr_eff     = write_address_q;
    ram_we          = 1'b0;
    line_done       = 1'b0;
    drop_evt        = 1'b0;
    short_evt       = 1'b0;

    if (bus.line_start) begin
      short_evt       = (state_q == ST_WRITE);
      state_d         = ST_WRITE;
      wr_addr_eff     = '0;
      write_address_d = '0;
      ram_we          = bus.pixel_valid;
    end else if (state_q == ST_WRITE) begin
      ram_we = bus.pixel_valid;
    end else begin
      drop_evt = bus.pixel_valid;
    end

    if (ram_we) begin
      if (wr_addr_eff == LAST_ADDR) begin
        line_done       = 1'b1;
        state_d         = ST_IDLE;
        write_address_d = '0;
      end else begin
        write_address_d = wr_addr_eff + ADDR_WIDTH'(1);
      end
    end
  end

  always_comb begin
    wr_idx      = (wr_bank_q ? BANK_OFS : '0) + RAM_AW'(wr_addr_eff);
    rd_idx      = (rd_bank_q ? BANK_OFS : '0) + RAM_AW'(bus.read_address);
    rd_in_range = (bus.read_address <= LAST_ADDR);
  end

  // Completing a line swaps the banks on the same edge, so line_ready, the new rd_bank,
  // line_valid and line_count all become visible together in the following cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      write_address_q <= '0;
      wr_bank_q       <= 1'b0;
      rd_bank_q       <= 1'b1;
      line_ready_q    <= 1'b0;
      line_valid_q    <= 1'b0;
      line_count_q    <= '0;
      drop_error_q    <= 1'b0;
      short_error_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      write_address_q <= write_address_d;
      line_ready_q    <= line_done;
      if (line_done) begin
        wr_bank_q    <= ~wr_bank_q;
        rd_bank_q    <= ~rd_bank_q;
        line_valid_q <= 1'b1;
        line_count_q <= line_count_q + ADDR_WIDTH'(1);
      end
      drop_error_q  <= drop_evt  | (drop_error_q  & ~bus.error_clear);
      short_error_q <= short_evt | (short_error_q & ~bus.error_clear);
    end
  end

  always_ff @(posedge clock) begin
    if (ram_we) begin
      mem[wr_idx] <= bus.pixel_in;
    end
  end

  // Bank contents are undefined until the first line completes, so reads return 0 then.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= '0;
    end else if (bus.read_enable) begin
      data_out_q <= (line_valid_q && rd_in_range) ? mem[rd_idx] : '0;
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.line_ready  = line_ready_q;
  assign bus.line_valid  = line_valid_q;
  assign bus.line_count  = line_count_q;
  assign bus.drop_error  = drop_error_q;
  assign bus.short_error = short_error_q;
  assign state_debug     = state_q;

endmodule

// File: tb/tb_pipeline_to_buffer.sv
// Directed bench for the ping-pong line buffer: read-vector table after a ramp line, plus
// hand-written sequences for swap, errors, short lines and mid-line reset.
module tb_pipeline_to_buffer;
  localparam int DW = 8;
  localparam int LW = 640;
  localparam int AW = 10;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic [0:0] state_debug;

  int n_checks  = 0;
  int n_errors  = 0;
  int ready_cnt = 0;
  int ready_before;

  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] exp;
  } rd_vec_t;

  rd_vec_t vecs[9];

  pipeline_to_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  pipeline_to_buffer #(.DATA_WIDTH(DW), .LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .state_debug (state_debug)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bus.line_ready) ready_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.line_start   = 1'b0;
    bus.pixel_valid  = 1'b0;
    bus.pixel_in     = '0;
    bus.read_enable  = 1'b0;
    bus.read_address = '0;
    bus.error_clear  = 1'b0;
  endtask

  // One clock: inputs are applied 1 time unit after a rising edge and outputs are sampled
  // 1 time unit after the next rising edge.
  task automatic cyc(input logic ls, input logic pv, input logic [DW-1:0] px,
                     input logic re, input logic [AW-1:0] ra, input logic ec);
    bus.line_start   = ls;
    bus.pixel_valid  = pv;
    bus.pixel_in     = px;
    bus.read_enable  = re;
    bus.read_address = ra;
    bus.error_clear  = ec;
    @(posedge clock);
    #1;
    drive_idle();
  endtask

  // n pixels; constant value if use_const, else ramp (first + i) mod 256.
  task automatic fill(input int n, input int first, input logic use_const,
                      input logic [DW-1:0] cval);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b1, use_const ? cval : DW'((first + i) % 256), 1'b0, '0, 1'b0);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic read_check(input string name, input logic pv, input logic [DW-1:0] px,
                            input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    exp_q.push_back(exp);
    cyc(1'b0, pv, px, 1'b1, addr, 1'b0);
    check(name, bus.data_out, exp_q.pop_front());
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{addr: 10'd0,    exp: 8'd0};
    vecs[1] = '{addr: 10'd5,    exp: 8'd5};
    vecs[2] = '{addr: 10'd639,  exp: 8'd127};
    vecs[3] = '{addr: 10'd255,  exp: 8'd255};
    vecs[4] = '{addr: 10'd256,  exp: 8'd0};
    vecs[5] = '{addr: 10'd300,  exp: 8'd44};
    vecs[6] = '{addr: 10'd640,  exp: 8'd0};
    vecs[7] = '{addr: 10'd700,  exp: 8'd0};
    vecs[8] = '{addr: 10'd1023, exp: 8'd0};

    drive_idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_data_out",    bus.data_out,    0);
    check("rst_line_ready",  bus.line_ready,  0);
    check("rst_line_valid",  bus.line_valid,  0);
    check("rst_line_count",  bus.line_count,  0);
    check("rst_drop_error",  bus.drop_error,  0);
    check("rst_short_error", bus.short_error, 0);
    check("rst_state",       state_debug,     0);
    do_reset();

    read_check("pre_line_read", 1'b0, '0, 10'd5, 8'd0);

    // 1. ramp line
    cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    ready_before = ready_cnt;
    fill(LW, 0, 1'b0, '0);
    check("t1_line_ready", bus.line_ready, 1);
    check("t1_line_count", bus.line_count, 1);
    check("t1_line_valid", bus.line_valid, 1);
    cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    check("t1_ready_pulse_width", bus.line_ready, 0);
    check("t1_ready_pulses", ready_cnt - ready_before, 1);
    for (int i = 0; i < 9; i++) begin
      read_check($sformatf("t1_vec%0d", i), 1'b0, '0, vecs[i].addr, vecs[i].exp);
    end
    read_check("t1_rd_pre_hold", 1'b0, '0, 10'd5, 8'd5);
    cyc(1'b0, 1'b0, '0, 1'b0, 10'd0, 1'b0);
    check("t1_data_hold", bus.data_out, 5);

    // 2. back-to-back lines A (0x11) and B (0x22), read in the swap cycle
    cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    fill(LW, 0, 1'b1, 8'h11);
    check("t2_a_ready", bus.line_ready, 1);
    read_check("t2_swap_cycle_read", 1'b0, '0, 10'd0, 8'h11);
    cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    fill(320, 0, 1'b1, 8'h22);
    read_check("t2_b_fill_rd0",   1'b1, 8'h22, 10'd0,   8'h11);
    read_check("t2_b_fill_rd319", 1'b1, 8'h22, 10'd319, 8'h11);
    read_check("t2_b_fill_rd639", 1'b1, 8'h22, 10'd639, 8'h11);
    fill(LW - 323, 0, 1'b1, 8'h22);
    check("t2_b_ready", bus.line_ready, 1);
    check("t2_b_count", bus.line_count, 3);
    read_check("t2_b_rd0",   1'b0, '0, 10'd0,   8'h22);
    read_check("t2_b_rd639", 1'b0, '0, 10'd639, 8'h22);

    // 3. stray pixel while idle
    cyc(1'b0, 1'b1, 8'h55, 1'b0, '0, 1'b0);
    check("t3_drop_set", bus.drop_error, 1);
    check("t3_count_same", bus.line_count, 3);
    check("t3_state_idle", state_debug, 0);
    cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    check("t3_drop_clear", bus.drop_error, 0);
    cyc(1'b0, 1'b1, 8'h56, 1'b0, '0, 1'b1);
    check("t3_set_wins", bus.drop_error, 1);
    cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    check("t3_drop_clear2", bus.drop_error, 0);

    // 4. short line: 100 pixels, restart, full ramp offset by 7
    ready_before = ready_cnt;
    cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    fill(100, 0, 1'b1, 8'h33);
    check("t4_no_short_yet", bus.short_error, 0);
    cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    check("t4_short_set", bus.short_error, 1);
    check("t4_no_early_ready", ready_cnt - ready_before, 0);
    fill(LW, 7, 1'b0, '0);
    check("t4_line_ready", bus.line_ready, 1);
    cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    check("t4_one_ready", ready_cnt - ready_before, 1);
    check("t4_count", bus.line_count, 4);
    read_check("t4_rd0",   1'b0, '0, 10'd0,   8'd7);
    read_check("t4_rd99",  1'b0, '0, 10'd99,  8'd106);
    read_check("t4_rd639", 1'b0, '0, 10'd639, 8'd134);
    cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    check("t4_short_clear", bus.short_error, 0);

    // 5. line_start together with pixel 0
    cyc(1'b1, 1'b1, 8'hAB, 1'b0, '0, 1'b0);
    fill(LW - 1, 0, 1'b1, 8'h44);
    check("t5_line_ready", bus.line_ready, 1);
    check("t5_count", bus.line_count, 5);
    check("t5_no_short", bus.short_error, 0);
    read_check("t5_rd0",   1'b0, '0, 10'd0,   8'hAB);
    read_check("t5_rd1",   1'b0, '0, 10'd1,   8'h44);
    read_check("t5_rd700", 1'b0, '0, 10'd700, 8'h00);

    // 6. reset in the middle of a line
    read_check("t6_pre_rd0", 1'b0, '0, 10'd0, 8'hAB);
    cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    fill(300, 0, 1'b0, '0);
    bus.pixel_valid = 1'b1;
    bus.pixel_in    = 8'h99;
    reset_n = 1'b0;
    #1;
    check("t6_rst_data_out",   bus.data_out,    0);
    check("t6_rst_line_ready", bus.line_ready,  0);
    check("t6_rst_line_valid", bus.line_valid,  0);
    check("t6_rst_line_count", bus.line_count,  0);
    check("t6_rst_drop",       bus.drop_error,  0);
    check("t6_rst_short",      bus.short_error, 0);
    check("t6_rst_state",      state_debug,     0);
    drive_idle();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    read_check("t6_post_rst_rd", 1'b0, '0, 10'd5, 8'd0);
    ready_before = ready_cnt;
    cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    fill(LW, 0, 1'b0, '0);
    check("t6_line_ready", bus.line_ready, 1);
    check("t6_count", bus.line_count, 1);
    check("t6_no_drop", bus.drop_error, 0);
    read_check("t6_rd5", 1'b0, '0, 10'd5, 8'd5);
    check("t6_one_ready", ready_cnt - ready_before, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
